// File: rtl/gpt_pkg.sv
// ============================================================================
//  Module      : gpt_pkg
//  Description : Shared types and constants for the general-purpose timer
//                external-trigger path (prescaler select encodings, sync depth).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpt_pkg;

    // Prescaler-select width at the default configuration.
    localparam int GPT_PSC_W = 2;

    typedef logic [GPT_PSC_W-1:0] etps_t;

    // Prescaler-select encodings: ratio = 2^etps.
    localparam etps_t ETPS_DIV1 = etps_t'(0);
    localparam etps_t ETPS_DIV2 = etps_t'(1);
    localparam etps_t ETPS_DIV4 = etps_t'(2);
    localparam etps_t ETPS_DIV8 = etps_t'(3);

    // Depth of the metastability synchroniser on the ETR pin.
    localparam int ETR_SYNC_STAGES = 2;

endpackage : gpt_pkg

`default_nettype wire

// File: rtl/etr_filter.sv
// ============================================================================
//  Module      : etr_filter
//  Description : Digital glitch filter for the conditioned ETR level. A new
//                level is accepted only after FILT_LEN consecutive samples
//                that differ from the currently accepted level.
//  Ports       : clk_i     - kernel clock
//                aresetn_i - synchronous active-low reset
//                d_i       - sampled level (already synchronised)
//                q_o       - accepted (filtered) level
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module etr_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk_i,
    input  logic aresetn_i,
    input  logic d_i,
    output logic q_o
);

    localparam int            c_cnt_w = $clog2(FILT_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FILT_LEN - 1);

    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               lvl_q, lvl_d;

    // The counter tracks how many samples in a row have disagreed with the
    // accepted level; a sample that agrees again is the "mismatch" that
    // restarts qualification.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (d_i != lvl_q) begin
            if (cnt_q == c_last) begin
                lvl_d = d_i;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign q_o = lvl_q;

endmodule : etr_filter

`default_nettype wire

// File: rtl/etr_prescaler.sv
// ============================================================================
//  Module      : etr_prescaler
//  Description : External-trigger conditioner for the general-purpose timer.
//                Synchronises ETR, applies polarity, optionally filters it,
//                detects active edges and divides the edge rate by 2^etps_i.
//  Build option: ETR_FILTER_EN - inserts etr_filter after the polarity XOR.
//  Ports       : clk_i     - kernel clock
//                aresetn_i - synchronous active-low reset
//                en_i      - prescaler enable (counter advances only when 1)
//                etr_i     - raw asynchronous trigger pin
//                etp_i     - polarity (0 rising active, 1 falling active)
//                etps_i    - prescaler select, ratio 2^etps_i
//                etrf_o    - conditioned ETR level
//                edge_o    - one-cycle pulse per active edge
//                etrp_o    - one-cycle pulse per 2^etps_i active edges
//                cnt_o     - current edge count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module etr_prescaler
    import gpt_pkg::*;
#(
    parameter int PSC_W    = 2,
    parameter int CNT_W    = 2**PSC_W - 1,
    parameter int FILT_LEN = 4
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic             en_i,
    input  logic             etr_i,
    input  logic             etp_i,
    input  logic [PSC_W-1:0] etps_i,
    output logic             etrf_o,
    output logic             edge_o,
    output logic             etrp_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int c_top = ETR_SYNC_STAGES - 1;

    logic [ETR_SYNC_STAGES-1:0] sync_q, sync_d;
    // Tracks which sync stages hold pin-derived data rather than reset zeros.
    logic [ETR_SYNC_STAGES-1:0] vld_q, vld_d;
    logic                       etrf_q, etrf_d;
    logic                       prev_q, prev_d;
    logic                       armed_q, armed_d;
    logic                       edge_q, edge_d;
    logic                       etrp_q, etrp_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PSC_W-1:0]           etps_q, etps_d;

    logic                       w_pol_lvl;
    logic                       w_etrf_src;
    logic                       w_edge;
    logic                       w_etps_chg;
    logic [CNT_W-1:0]           w_mask;

    assign w_pol_lvl = sync_q[c_top] ^ etp_i;

`ifdef ETR_FILTER_EN
    etr_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .d_i       (w_pol_lvl),
        .q_o       (w_etrf_src)
    );
`else
    assign w_etrf_src = w_pol_lvl;
`endif

    // Terminal count for the active ratio: a zero-extended run of etps_q ones.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < CNT_W; b++) begin
            w_mask[b] = (b < int'(etps_q));
        end
    end

    assign w_etps_chg = (etps_i != etps_q);

    // Edges are gated until the pin has genuinely been seen inactive, so a
    // pin already active at reset release does not look like an edge against
    // the zeroed previous-level flop.
    assign w_edge = armed_q & etrf_q & ~prev_q;

    always_comb begin
        sync_d  = {sync_q[ETR_SYNC_STAGES-2:0], etr_i};
        vld_d   = {vld_q[ETR_SYNC_STAGES-2:0], 1'b1};
        etrf_d  = w_etrf_src;
        prev_d  = etrf_q;
        armed_d = armed_q | (vld_q[c_top] & ~w_pol_lvl);
        edge_d  = w_edge;
        etps_d  = etps_i;
        etrp_d  = 1'b0;
        cnt_d   = cnt_q;
        if (w_etps_chg) begin
            // Ratio change: drop the partial count, ignore a coincident edge.
            cnt_d = '0;
        end else if (w_edge && en_i) begin
            if (cnt_q == w_mask) begin
                cnt_d  = '0;
                etrp_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            sync_q  <= '0;
            vld_q   <= '0;
            etrf_q  <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            edge_q  <= 1'b0;
            etrp_q  <= 1'b0;
            cnt_q   <= '0;
            etps_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            etrf_q  <= etrf_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            edge_q  <= edge_d;
            etrp_q  <= etrp_d;
            cnt_q   <= cnt_d;
            etps_q  <= etps_d;
        end
    end

    assign etrf_o = etrf_q;
    assign edge_o = edge_q;
    assign etrp_o = etrp_q;
    assign cnt_o  = cnt_q;

endmodule : etr_prescaler

`default_nettype wire

// File: tb/tb_etr_prescaler.sv
// ============================================================================
//  Module      : tb_etr_prescaler
//  Description : Self-checking bench for etr_prescaler (default and wide
//                prescaler configurations, optional ETR_FILTER_EN build).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_etr_prescaler;
    import gpt_pkg::*;

`ifdef ETR_FILTER_EN
    localparam int FLT = 4;
`else
    localparam int FLT = 0;
`endif
    // Cycles from driving the pin to edge_o being visible.
    localparam int LAT = 4 + FLT;

    logic       clk = 1'b0;
    logic       aresetn_i = 1'b0;
    logic       en_i = 1'b0;
    logic       etr_i = 1'b0;
    logic       etp_i = 1'b0;
    logic [1:0] etps_i = 2'd0;
    logic       etrf_o, edge_o, etrp_o;
    logic [2:0] cnt_o;

    logic       en_w = 1'b0;
    logic [2:0] etps_w = 3'd7;
    logic       etrf_w, edge_w, etrp_w;
    logic [6:0] cnt_w;

    etr_prescaler #(.PSC_W(2), .FILT_LEN(4)) dut (
        .clk_i(clk), .aresetn_i(aresetn_i), .en_i(en_i), .etr_i(etr_i),
        .etp_i(etp_i), .etps_i(etps_i), .etrf_o(etrf_o), .edge_o(edge_o),
        .etrp_o(etrp_o), .cnt_o(cnt_o)
    );

    etr_prescaler #(.PSC_W(3), .FILT_LEN(4)) dut_w (
        .clk_i(clk), .aresetn_i(aresetn_i), .en_i(en_w), .etr_i(etr_i),
        .etp_i(etp_i), .etps_i(etps_w), .etrf_o(etrf_w), .edge_o(edge_w),
        .etrp_o(etrp_w), .cnt_o(cnt_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic etrp; int cnt; } exp_t;
    typedef struct { logic [1:0] etps; logic en; int nedge; } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_edge = 0;
    int   n_etrp_w = 0;
    bit   mon_en = 1'b0;

    int   m_cnt = 0;
    int   m_etps = 0;
    bit   m_en = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every edge_o must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (edge_o) begin
                n_edge++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_edge actual=1 required=0 (cyc %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("edge_cycle", cyc, e.cyc);
                    chk("etrp", int'(etrp_o), int'(e.etrp));
                    chk("cnt", int'(cnt_o), e.cnt);
                end
            end else if (etrp_o) begin
                chk("etrp_without_edge", 1, 0);
            end
            if (etrp_w) n_etrp_w++;
        end
    end

    // Model of the counter for one active edge; chg marks an etps change
    // landing in the same cycle as that edge.
    task automatic push_exp(input int lat, input bit chg);
        exp_t e;
        e.cyc = cyc + lat;
        e.etrp = 1'b0;
        if (chg) begin
            m_cnt = 0;
        end else if (m_en) begin
            if (m_cnt == (1 << m_etps) - 1) begin
                e.etrp = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_edge(input bit chg, input int new_etps);
        @(negedge clk);
        push_exp(LAT, chg);
        etr_i = ~etp_i;
        repeat (LAT - 1) @(negedge clk);
        if (chg) begin
            etps_i = 2'(new_etps);
            m_etps = new_etps;
        end
        etr_i = etp_i;
        repeat (FLT) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        if (int'(v.etps) != m_etps) begin
            @(negedge clk);
            etps_i = v.etps;
            m_etps = int'(v.etps);
            m_cnt  = 0;
            repeat (2) @(negedge clk);
            chk("cnt_clear_on_etps", int'(cnt_o), 0);
        end
        @(negedge clk);
        en_i = v.en;
        m_en = v.en;
        for (int i = 0; i < v.nedge; i++) do_edge(1'b0, 0);
        wait_drain();
        chk("cnt_after_vector", int'(cnt_o), m_cnt);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{ETPS_DIV4, 1'b1, 12};
        vecs[1] = '{ETPS_DIV1, 1'b1, 3};
        vecs[2] = '{ETPS_DIV2, 1'b1, 4};
        vecs[3] = '{ETPS_DIV4, 1'b1, 2};
        vecs[4] = '{ETPS_DIV4, 1'b0, 5};
        vecs[5] = '{ETPS_DIV4, 1'b1, 3};

        // Reset with the pin already high.
        etr_i = 1'b1;
        aresetn_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_etrf", int'(etrf_o), 0);
        chk("rst_edge", int'(edge_o), 0);
        chk("rst_etrp", int'(etrp_o), 0);
        chk("rst_cnt", int'(cnt_o), 0);
        chk("rst_cnt_w", int'(cnt_w), 0);
        aresetn_i = 1'b1;
        mon_en = 1'b1;
        repeat (10 + FLT) @(negedge clk);
        chk("no_edge_after_release", n_edge, 0);
        etr_i = 1'b0;
        repeat (6 + FLT) @(negedge clk);

        // First edge: exact latency, etps=0 so etrp coincides.
        en_i = 1'b1;
        m_en = 1'b1;
        do_edge(1'b0, 0);
        wait_drain();

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // etps change with a coincident edge at cnt=2.
        do_edge(1'b0, 0);
        wait_drain();
        chk("cnt_before_etps_change", int'(cnt_o), 2);
        do_edge(1'b1, 1);
        do_edge(1'b0, 0);
        do_edge(1'b0, 0);
        wait_drain();

        // Polarity flip with counting disabled yields one documented edge.
        @(negedge clk);
        en_i = 1'b0;
        m_en = 1'b0;
        etp_i = 1'b1;
        push_exp(2 + FLT, 1'b0);
        repeat (4 + FLT) @(negedge clk);
        etr_i = 1'b1;
        repeat (4 + FLT) @(negedge clk);
        wait_drain();
        run_vec('{ETPS_DIV2, 1'b1, 4});

        // Wide ratio on the PSC_W=3 instance.
        @(negedge clk);
        en_w = 1'b1;
        for (int i = 0; i < 128; i++) begin
            do_edge(1'b0, 0);
            if (i == 126) begin
                wait_drain();
                chk("wide_cnt_127", int'(cnt_w), 127);
                chk("wide_no_etrp_yet", n_etrp_w, 0);
            end
        end
        wait_drain();
        chk("wide_cnt_wrap", int'(cnt_w), 0);
        chk("wide_one_etrp", n_etrp_w, 1);
        en_w = 1'b0;

`ifdef ETR_FILTER_EN
        begin
            int before;
            before = n_edge;
            @(negedge clk);
            etr_i = ~etp_i;
            repeat (3) @(negedge clk);
            etr_i = etp_i;
            repeat (12) @(negedge clk);
            chk("glitch_suppressed", n_edge, before);
            @(negedge clk);
            push_exp(8, 1'b0);
            etr_i = ~etp_i;
            repeat (4) @(negedge clk);
            etr_i = etp_i;
            repeat (8) @(negedge clk);
            wait_drain();
            @(negedge clk);
            etr_i = ~etp_i;
            repeat (4) @(negedge clk);
            mon_en = 1'b0;
            aresetn_i = 1'b0;
            @(negedge clk);
            chk("filt_cnt_reset", int'(dut.u_filt.cnt_q), 0);
            chk("filt_rst_cnt", int'(cnt_o), 0);
            chk("filt_rst_edge", int'(edge_o), 0);
            etr_i = etp_i;
            aresetn_i = 1'b1;
            exp_q.delete();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=expired required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_etr_prescaler

`default_nettype wire
